// File: rtl/count_especial_seq.sv
// Sequencer for the count_especial up/down counter: sweeps the count between
// latched lower/upper limits for n_loops round trips, then parks it at zero.
module count_especial_seq #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         abort,
  input  logic [W-1:0] up_lim,
  input  logic [W-1:0] lo_lim,
  input  logic [W-1:0] n_loops,
  input  logic [W-1:0] count,
  output logic         cnt_rst,
  output logic         cnt_ctrl,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic [W-1:0] loop_cnt
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_UP    = 3'd2;
  localparam logic [2:0] S_DOWN  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]   state, state_nxt;
  logic [W-1:0] up_q, lo_q, n_q;
  logic         err_q;
  logic         cfg_ok, accept, at_lo, last;

  assign cfg_ok = (lo_lim < up_lim) && (n_loops != '0);
  assign accept = (state == S_IDLE) && start && cfg_ok && !abort;
  assign at_lo  = (count <= lo_q);
  assign last   = (loop_cnt + W'(1)) == n_q;

  // The counter cannot hold, so direction is decided from the live count.
  always_comb begin
    cnt_rst   = 1'b1;
    cnt_ctrl  = 1'b1;
    state_nxt = state;
    case (state)
      S_IDLE:  if (start && cfg_ok) state_nxt = S_CLEAR;
      S_CLEAR: state_nxt = S_UP;
      S_UP: begin
        cnt_rst = 1'b0;
        if (count >= up_q) begin
          cnt_ctrl  = 1'b0;
          state_nxt = S_DOWN;
        end
      end
      S_DOWN: begin
        cnt_rst = 1'b0;
        if (!at_lo) begin
          cnt_ctrl = 1'b0;
        end else if (last) begin
          cnt_rst   = 1'b1;
          state_nxt = S_DONE;
        end else begin
          state_nxt = S_UP;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (abort) state_nxt = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      up_q     <= '0;
      lo_q     <= '0;
      n_q      <= '0;
      loop_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      state <= state_nxt;
      err_q <= (state == S_IDLE) && start && !cfg_ok && !abort;
      if (accept) begin
        up_q     <= up_lim;
        lo_q     <= lo_lim;
        n_q      <= n_loops;
        loop_cnt <= '0;
      end else if (!abort && state == S_DOWN && at_lo) begin
        loop_cnt <= loop_cnt + W'(1);
      end
    end
  end

  assign busy = (state == S_CLEAR) || (state == S_UP) || (state == S_DOWN);
  assign done = (state == S_DONE);
  assign err  = err_q;

endmodule

// File: tb/tb_count_especial_seq.sv
// Bench for count_especial_seq: a 4-bit counter model closes the loop and the
// expected count trace of each run is built from the limits as a queue.
module tb_count_especial_seq;

  logic       clk = 1'b0;
  logic       rst, start, abort;
  logic [3:0] up_lim, lo_lim, n_loops;
  logic [3:0] count = '0;
  logic       cnt_rst, cnt_ctrl, busy, done, err;
  logic [3:0] loop_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // External counter being sequenced
  always @(posedge clk)
    count <= cnt_rst ? 4'd0 : (cnt_ctrl ? count + 4'd1 : count - 4'd1);

  count_especial_seq #(.W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .up_lim(up_lim), .lo_lim(lo_lim), .n_loops(n_loops), .count(count),
    .cnt_rst(cnt_rst), .cnt_ctrl(cnt_ctrl), .busy(busy), .done(done),
    .err(err), .loop_cnt(loop_cnt)
  );

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    up_lim = '0; lo_lim = '0; n_loops = '0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({cnt_rst, cnt_ctrl, busy, done, err, loop_cnt} !== {5'b11000, 4'd0}) begin
      n_bad++;
      $display("FAIL reset_outputs: got rst/ctrl/busy/done/err/loop=%b%b%b%b%b/%0d required 11000/0",
               cnt_rst, cnt_ctrl, busy, done, err, loop_cnt);
    end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (count !== 4'd0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_idle: got count=%0d busy=%b required 0/0", count, busy);
    end
  endtask

  task automatic run_sequence(input string tag, input logic [3:0] up, input logic [3:0] lo,
                              input logic [3:0] n, input bit poke);
    logic [3:0] exp_q[$];
    int ui, li, ni;
    ui = int'(up); li = int'(lo); ni = int'(n);
    exp_q = {};
    for (int v = 0; v <= ui; v++) exp_q.push_back(4'(v));
    for (int i = 1; i <= ni; i++) begin
      for (int v = ui - 1; v >= li; v--) exp_q.push_back(4'(v));
      if (i < ni) for (int v = li + 1; v <= ui; v++) exp_q.push_back(4'(v));
    end

    @(negedge clk);
    start = 1'b1; up_lim = up; lo_lim = lo; n_loops = n;
    @(negedge clk);
    start = 1'b0;
    up_lim = 4'($urandom); lo_lim = 4'($urandom); n_loops = 4'($urandom);
    n_cmp++;
    if (busy !== 1'b1 || cnt_rst !== 1'b1 || loop_cnt !== 4'd0 || err !== 1'b0) begin
      n_bad++;
      $display("FAIL %s_clear: got busy/rst/loop/err=%b/%b/%0d/%b required 1/1/0/0",
               tag, busy, cnt_rst, loop_cnt, err);
    end

    foreach (exp_q[i]) begin
      @(negedge clk);
      start = 1'b0;
      if (poke && i == 2) begin
        start = 1'b1; up_lim = 4'd9; lo_lim = 4'd0; n_loops = 4'd1;
      end
      n_cmp++;
      if (count !== exp_q[i] || busy !== 1'b1 || done !== 1'b0 || err !== 1'b0) begin
        n_bad++;
        $display("FAIL %s_trace[%0d]: got count=%0d busy=%b done=%b err=%b required count=%0d busy=1 done=0 err=0",
                 tag, i, count, busy, done, err, exp_q[i]);
      end
    end

    @(negedge clk);
    start = 1'b0;
    n_cmp++;
    if (done !== 1'b1 || busy !== 1'b0 || count !== 4'd0 || loop_cnt !== n || cnt_rst !== 1'b1) begin
      n_bad++;
      $display("FAIL %s_done: got done=%b busy=%b count=%0d loop=%0d rst=%b required 1/0/0/%0d/1",
               tag, done, busy, count, loop_cnt, cnt_rst, n);
    end
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b0 || busy !== 1'b0 || loop_cnt !== n || err !== 1'b0) begin
      n_bad++;
      $display("FAIL %s_idle: got done=%b busy=%b loop=%0d err=%b required 0/0/%0d/0",
               tag, done, busy, loop_cnt, err, n);
    end
  endtask

  task automatic test_normal();
    run_sequence("normal", 4'd3, 4'd1, 4'd2, 1'b0);
  endtask

  task automatic test_full_range();
    run_sequence("full", 4'd15, 4'd0, 4'd1, 1'b0);
  endtask

  task automatic test_start_while_busy();
    run_sequence("busy_start", 4'd4, 4'd1, 4'd2, 1'b1);
  endtask

  task automatic test_bad_config();
    logic [3:0] cfg [3][3];
    logic [3:0] a, b;
    a = 4'($urandom_range(0, 15));
    b = 4'($urandom_range(0, int'(a)));
    cfg[0] = '{4'd2, 4'd2, 4'd1};
    cfg[1] = '{4'd5, 4'd1, 4'd0};
    cfg[2] = '{b, a, 4'($urandom_range(1, 15))};
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      start = 1'b1; up_lim = cfg[c][0]; lo_lim = cfg[c][1]; n_loops = cfg[c][2];
      @(negedge clk);
      start = 1'b0;
      n_cmp++;
      if (err !== 1'b1 || busy !== 1'b0 || cnt_rst !== 1'b1) begin
        n_bad++;
        $display("FAIL bad_cfg%0d_err: got err=%b busy=%b rst=%b required 1/0/1", c, err, busy, cnt_rst);
      end
      @(negedge clk);
      n_cmp++;
      if (err !== 1'b0 || busy !== 1'b0 || cnt_rst !== 1'b1 || done !== 1'b0) begin
        n_bad++;
        $display("FAIL bad_cfg%0d_after: got err=%b busy=%b rst=%b done=%b required 0/0/1/0",
                 c, err, busy, cnt_rst, done);
      end
    end
  endtask

  task automatic test_abort();
    bit found;
    @(negedge clk);
    start = 1'b1; up_lim = 4'd3; lo_lim = 4'd1; n_loops = 4'd2;
    @(negedge clk);
    start = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 60 && !found; c++) begin
      @(negedge clk);
      if (busy && cnt_ctrl && !cnt_rst && loop_cnt == 4'd1 && count == 4'd2) found = 1'b1;
    end
    n_cmp++;
    if (!found) begin
      n_bad++;
      $display("FAIL abort_reach: got no second-leg count=2 within 60 cycles required found");
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || cnt_rst !== 1'b1 || loop_cnt !== 4'd1) begin
      n_bad++;
      $display("FAIL abort_idle: got busy=%b done=%b rst=%b loop=%0d required 0/0/1/1",
               busy, done, cnt_rst, loop_cnt);
    end
    @(negedge clk);
    n_cmp++;
    if (count !== 4'd0 || done !== 1'b0 || loop_cnt !== 4'd1) begin
      n_bad++;
      $display("FAIL abort_park: got count=%0d done=%b loop=%0d required 0/0/1", count, done, loop_cnt);
    end
    repeat (3) begin
      @(negedge clk);
      n_cmp++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        n_bad++;
        $display("FAIL abort_quiet: got done=%b busy=%b required 0/0", done, busy);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    bit found;
    @(negedge clk);
    start = 1'b1; up_lim = 4'd5; lo_lim = 4'd2; n_loops = 4'd3;
    @(negedge clk);
    start = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 60 && !found; c++) begin
      @(negedge clk);
      if (busy && !cnt_ctrl && loop_cnt == 4'd1 && count < 4'd5) found = 1'b1;
    end
    n_cmp++;
    if (!found) begin
      n_bad++;
      $display("FAIL midrst_reach: got no DOWN leg within 60 cycles required found");
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++;
    if ({cnt_rst, cnt_ctrl, busy, done, err, loop_cnt} !== {5'b11000, 4'd0}) begin
      n_bad++;
      $display("FAIL midrst_outputs: got rst/ctrl/busy/done/err/loop=%b%b%b%b%b/%0d required 11000/0",
               cnt_rst, cnt_ctrl, busy, done, err, loop_cnt);
    end
    @(negedge clk);
    run_sequence("after_rst", 4'd6, 4'd3, 4'd2, 1'b0);
  endtask

  task automatic test_random();
    logic [3:0] lo, up, n;
    for (int r = 0; r < 8; r++) begin
      lo = 4'($urandom_range(0, 14));
      up = 4'($urandom_range(int'(lo) + 1, 15));
      n  = 4'($urandom_range(1, 4));
      run_sequence($sformatf("rand%0d", r), up, lo, n, bit'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_bad_config();
    test_full_range();
    test_abort();
    test_reset_mid_run();
    test_start_while_busy();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
